delay_pipe_prog: RTL and testbench

- Parametrised, run-time-programmable fixed-latency delay line for a valid-qualified data stream.
- Input words advance through MAX_DELAY shift stages, each holding {valid, data}; a stage selected by a programmable tap feeds a holding output register with a ready flag that the consumer clears.
- Generalises the fixed 9-stage delay block: width, maximum depth and actual delay are configurable, with pipeline-busy indication and overrun detection.

---
 rtl/delay_pipe_prog.sv | 117 +++++++++++
 tb/tb_delay_pipe_prog.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_pipe_prog.sv
// Run-time programmable delay line for a valid-qualified stream, with a held output word,
// consumer ready flag, busy indication and sticky overrun. Optional drop counter: DELAY_PIPE_DROP_CNT_EN.
module delay_pipe_prog #(
    parameter int DATA_W    = 8,
    parameter int MAX_DELAY = 16,
    parameter int DLY_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DLY_W-1:0]  dly_sel,
    input  logic              data_use,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] data_o,
    output logic              data_rd,
    output logic              busy,
`ifdef DELAY_PIPE_DROP_CNT_EN
    output logic [15:0]       drop_cnt,
`endif
    output logic              ovf
);

    localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(MAX_DELAY - 1);

    logic [MAX_DELAY-1:0] stg_vld;
    logic [DATA_W-1:0]    stg_data [MAX_DELAY];
    logic [DLY_W-1:0]     dly_q;
    logic [DLY_W-1:0]     dly_nxt;
    logic                 tap_vld;
    logic [DATA_W-1:0]    tap_data;
    logic                 ovf_set;

    assign busy    = |stg_vld;
    assign ovf_set = tap_vld & data_rd & ~data_use;

    always_comb begin
        dly_nxt = dly_sel;
        if (dly_sel > DLY_MAX) begin
            dly_nxt = DLY_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= '0;
            for (int k = 0; k < MAX_DELAY; k++) begin
                stg_data[k] <= '0;
            end
        end else begin
            stg_vld     <= {stg_vld[MAX_DELAY-2:0], en};
            stg_data[0] <= data_i;
            for (int k = 1; k < MAX_DELAY; k++) begin
                stg_data[k] <= stg_data[k-1];
            end
        end
    end

    // Tap only moves while the line is empty, so no in-flight word is duplicated or skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= '0;
        end else if (!busy && !en) begin
            dly_q <= dly_nxt;
        end
    end

    // Registered tap gives the extra cycle of latency (dly_q + 2 overall).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_vld  <= 1'b0;
            tap_data <= '0;
        end else begin
            tap_vld  <= stg_vld[dly_q];
            tap_data <= stg_data[dly_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            data_rd <= 1'b0;
        end else if (tap_vld) begin
            data_o  <= tap_data;
            data_rd <= 1'b1;
        end else if (data_use) begin
            data_rd <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef DELAY_PIPE_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (ovf_set) begin
            if (ovf_clr) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_delay_pipe_prog.sv
// Scoreboard bench for delay_pipe_prog: stimulus queues expected words with due cycles,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_delay_pipe_prog;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data_i;
    logic [3:0] dly_sel;
    logic       data_use;
    logic       ovf_clr;
    logic [7:0] data_o;
    logic       data_rd;
    logic       busy;
    logic       ovf;
`ifdef DELAY_PIPE_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    delay_pipe_prog #(.DATA_W(8), .MAX_DELAY(16), .DLY_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .data_i   (data_i),
        .dly_sel  (dly_sel),
        .data_use (data_use),
        .ovf_clr  (ovf_clr),
        .data_o   (data_o),
        .data_rd  (data_rd),
        .busy     (busy),
`ifdef DELAY_PIPE_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .ovf      (ovf)
    );

    typedef struct {
        int         due;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_rd  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: a due word must be presented exactly on its cycle; a rise with nothing due is spurious.
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL sb_missed: word 0x%0h due %0d never seen (cyc %0d)", sb[0].d, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (data_rd !== 1'b1 || data_o !== e.d) begin
                    failures++;
                    $display("FAIL sb_word: got rd=%b data=0x%0h expected rd=1 data=0x%0h (cyc %0d)",
                             data_rd, data_o, e.d, cyc);
                end
            end else if (data_rd && !prev_rd) begin
                checks++;
                failures++;
                $display("FAIL sb_spurious: got data_rd rise data=0x%0h expected no word (cyc %0d)", data_o, cyc);
            end
            prev_rd = data_rd;
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("wait_idle_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send(input logic [7:0] d, input int dly);
        exp_t e;
        en     = 1'b1;
        data_i = d;
        e.due  = cyc + 3 + dly;
        e.d    = d;
        sb.push_back(e);
        tick();
        en = 1'b0;
    endtask

    initial begin
        int last_due;
        int e_last;
        rst_n    = 1'b0;
        en       = 1'b0;
        data_i   = 8'h00;
        dly_sel  = 4'd5;
        data_use = 1'b1;
        ovf_clr  = 1'b0;

        // Reset values
        #1;
        check("rst_data_o", {24'b0, data_o}, 32'h0);
        check("rst_data_rd", {31'b0, data_rd}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_ovf", {31'b0, ovf}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset mid-stream with three words in flight: nothing may emerge
        for (int i = 0; i < 3; i++) begin
            en = 1'b1;
            data_i = 8'hC0 + 8'(i);
            tick();
        end
        en = 1'b0;
        check("mid_busy_before", {31'b0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_data_o", {24'b0, data_o}, 32'h0);
        check("mid_rst_data_rd", {31'b0, data_rd}, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_ovf", {31'b0, ovf}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) tick();
        check("post_rst_data_rd", {31'b0, data_rd}, 32'h0);
        check("post_rst_busy", {31'b0, busy}, 32'h0);

        // Latency sweep: 0 -> 2, 5 -> 7, 15 -> 17 edges
        dly_sel = 4'd0;
        wait_idle(); tick();
        send(8'hA5, 0);
        repeat (6) tick();
        dly_sel = 4'd5;
        wait_idle(); tick();
        send(8'hA5, 5);
        repeat (10) tick();
        dly_sel = 4'hF;
        wait_idle(); tick();
        send(8'hA5, 15);
        repeat (20) tick();

        // Held select: change 3 -> 9 while busy; in-flight words keep delay 3
        dly_sel = 4'd3;
        wait_idle(); tick();
        send(8'h31, 3);
        dly_sel = 4'd9;
        send(8'h32, 3);
        tick();
        send(8'h33, 3);
        wait_idle(); tick();
        send(8'h34, 9);
        repeat (14) tick();

        // Handshake: word held until consumed
        dly_sel  = 4'd0;
        data_use = 1'b0;
        wait_idle(); tick();
        send(8'h11, 0);
        wait_until(sb[0].due);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_data_rd", {31'b0, data_rd}, 32'h1);
            check("hold_data_o", {24'b0, data_o}, 32'h11);
        end
        data_use = 1'b1;
        tick();
        data_use = 1'b0;
        check("use_data_rd", {31'b0, data_rd}, 32'h0);
        check("use_data_o", {24'b0, data_o}, 32'h11);

        // Overrun: two consecutive words with no consumption
        dly_sel = 4'd2;
        wait_idle(); tick();
        check("ovf_before", {31'b0, ovf}, 32'h0);
        send(8'h01, 2);
        send(8'h02, 2);
        last_due = cyc + 4;
        wait_until(last_due + 1);
        check("ovf_set", {31'b0, ovf}, 32'h1);
        check("ovf_data_o", {24'b0, data_o}, 32'h02);
`ifdef DELAY_PIPE_DROP_CNT_EN
        check("drop_cnt_1", {16'b0, drop_cnt}, 32'd1);
`endif
        send(8'h03, 2);
        last_due = cyc + 4;
        wait_until(last_due - 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_set_wins", {31'b0, ovf}, 32'h1);
        check("ovf_data_o3", {24'b0, data_o}, 32'h03);
`ifdef DELAY_PIPE_DROP_CNT_EN
        check("drop_cnt_clr_inc", {16'b0, drop_cnt}, 32'd1);
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'b0, ovf}, 32'h0);
`ifdef DELAY_PIPE_DROP_CNT_EN
        check("drop_cnt_cleared", {16'b0, drop_cnt}, 32'd0);
`endif

        // Streaming: 32 back-to-back words at maximum delay
        data_use = 1'b1;
        dly_sel  = 4'd15;
        wait_idle(); tick();
        for (int i = 0; i < 32; i++) begin
            send(8'(i), 15);
        end
        e_last = cyc;
        wait_until(e_last + 15);
        check("stream_busy_hi", {31'b0, busy}, 32'h1);
        tick();
        check("stream_busy_lo", {31'b0, busy}, 32'h0);
        repeat (4) tick();
        check("stream_ovf", {31'b0, ovf}, 32'h0);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
